// File: rtl/sam_pkg.sv
// Shared definitions for the SAM CPU bus memory responder: state encoding, word width and
// request op encoding.
package sam_pkg;

  localparam int unsigned SAM_WORD_W = 16;

  // Responder FSM state encoding
  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StBusy = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  // Latched request type
  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  // Width of the latency down-counter; LATENCY is limited to 1..15
  localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/sam_ram_array.sv
// Synchronous single-port word array: write enable plus a registered, enabled read port.
// No reset; contents and the read register power up undefined.
module sam_ram_array #(
  parameter int unsigned DataW = 16,
  parameter int unsigned AddrW = 8
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic             re_i,
  input  logic [AddrW-1:0] addr_i,
  input  logic [DataW-1:0] wdata_i,
  output logic [DataW-1:0] rdata_o
);

  localparam int unsigned Depth = 1 << AddrW;

  logic [DataW-1:0] mem_q [Depth];
  logic [DataW-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_bus_responder.sv
// Memory-side responder for the SAM CPU bus: latches a read/write request, performs it on the
// word array after LATENCY cycles and drives the active-low wait_ stall back to the controller.
module mem_bus_responder
  import sam_pkg::*;
#(
  parameter int unsigned DATA_W  = SAM_WORD_W,
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned LATENCY = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              wait_,
  output logic              err
);

  localparam logic [CNT_W-1:0] CntLoad = (LATENCY > 1) ? CNT_W'(LATENCY - 2) : '0;

  logic req, conflict, any_strobe;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              err_q, err_d;
  logic              rd_valid_q, rd_valid_d;

  // Access strobe and the address/data/op it uses this cycle
  logic              acc;
  logic              acc_op;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata;

  logic              ram_we, ram_re;
  logic [DATA_W-1:0] ram_rdata;

  assign req        = mem_read ^ mem_write;
  assign conflict   = mem_read & mem_write;
  assign any_strobe = mem_read | mem_write;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    acc       = 1'b0;
    acc_op    = op_q;
    acc_addr  = addr_q;
    acc_wdata = wdata_q;

    case (state_q)
      StIdle: begin
        if (req) begin
          op_d    = mem_write ? OP_WRITE : OP_READ;
          addr_d  = addr;
          wdata_d = wdata;
          if (LATENCY == 1) begin
            // Single-cycle latency: access straight from the live bus values
            acc       = 1'b1;
            acc_op    = op_d;
            acc_addr  = addr;
            acc_wdata = wdata;
            state_d   = StDone;
          end else begin
            cnt_d   = CntLoad;
            state_d = StBusy;
          end
        end
      end
      StBusy: begin
        if (!req) begin
          state_d = StIdle;
        end else if (cnt_q == '0) begin
          acc     = 1'b1;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StDone: begin
        if (!any_strobe) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Reset must also suppress an access completing on the same edge
  assign ram_we = acc & (acc_op == OP_WRITE) & ~reset;
  assign ram_re = acc & (acc_op == OP_READ) & ~reset;

  assign err_d      = (state_q == StIdle) & conflict;
  assign rd_valid_d = rd_valid_q | ram_re;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    op_q    <= op_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end

  sam_ram_array #(
    .DataW(DATA_W),
    .AddrW(ADDR_W)
  ) u_ram (
    .clk_i  (clk),
    .we_i   (ram_we),
    .re_i   (ram_re),
    .addr_i (acc_addr),
    .wdata_i(acc_wdata),
    .rdata_o(ram_rdata)
  );

  // The array read register has no reset, so rdata reads 0 until the first completed read
  assign rdata = rd_valid_q ? ram_rdata : '0;
  assign wait_ = ~(any_strobe & (state_q != StDone));
  assign err   = err_q;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Bench for mem_bus_responder: LATENCY=3 and LATENCY=1 instances share one stimulus stream and
// are checked against transaction-level memory models.
module tb_mem_bus_responder;

  logic        clk = 1'b0;
  logic        reset, mem_read, mem_write;
  logic [7:0]  addr;
  logic [15:0] wdata;
  logic [15:0] rdata3, rdata1;
  logic        wait3, wait1, err3, err1;

  int errors = 0;
  int checks = 0;

  logic [15:0] m3 [256];
  logic [15:0] m1 [256];
  logic [15:0] last3 = '0;
  logic [15:0] last1 = '0;
  logic [7:0]  pool [8] = '{8'h00, 8'h05, 8'h06, 8'h10, 8'h20, 8'h30, 8'h7F, 8'hFF};

  always #5 clk = ~clk;

  mem_bus_responder #(.DATA_W(16), .ADDR_W(8), .LATENCY(3)) u_dut3 (
    .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write), .addr(addr),
    .wdata(wdata), .rdata(rdata3), .wait_(wait3), .err(err3)
  );

  mem_bus_responder #(.DATA_W(16), .ADDR_W(8), .LATENCY(1)) u_dut1 (
    .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write), .addr(addr),
    .wdata(wdata), .rdata(rdata1), .wait_(wait1), .err(err1)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // One request held for `hold` cycles, then one idle cycle. A request completes only if held
  // for at least LATENCY cycles; otherwise it is aborted without side effects.
  task automatic xact(input bit wr, input logic [7:0] a, input logic [15:0] d,
                      input int hold, input bit wiggle);
    logic [15:0] new3, new1;
    bit done3, done1;
    done3 = (hold >= 3);
    done1 = (hold >= 1);
    new3  = (!wr && done3) ? m3[a] : last3;
    new1  = (!wr && done1) ? m1[a] : last1;
    for (int k = 0; k < hold; k++) begin
      if (k == 0 || !wiggle) begin
        addr = a; wdata = d; mem_read = !wr; mem_write = wr;
      end else begin
        addr = a + 8'd1; wdata = ~d;
        if (k >= 2) begin
          mem_read = wr; mem_write = !wr;
        end
      end
      sample();
      check_eq("wait3", 32'(wait3), 32'(k >= 3));
      check_eq("wait1", 32'(wait1), 32'(k >= 1));
      check_eq("rdata3", 32'(rdata3), 32'((k >= 3) ? new3 : last3));
      check_eq("rdata1", 32'(rdata1), 32'((k >= 1) ? new1 : last1));
      check_eq("err3", 32'(err3), 32'd0);
      check_eq("err1", 32'(err1), 32'd0);
      next_cycle();
    end
    mem_read = 1'b0; mem_write = 1'b0;
    sample();
    check_eq("idle_wait3", 32'(wait3), 32'd1);
    check_eq("idle_wait1", 32'(wait1), 32'd1);
    check_eq("idle_rdata3", 32'(rdata3), 32'(new3));
    check_eq("idle_rdata1", 32'(rdata1), 32'(new1));
    next_cycle();
    if (wr && done3) m3[a] = d;
    if (wr && done1) m1[a] = d;
    last3 = new3;
    last1 = new1;
  endtask

  // Both strobes high in IDLE for n cycles: err pulses once per sampled cycle, no access
  task automatic conflict(input int n);
    for (int k = 0; k < n; k++) begin
      mem_read = 1'b1; mem_write = 1'b1; addr = pool[$urandom_range(7)]; wdata = 16'($urandom);
      sample();
      check_eq("cf_wait3", 32'(wait3), 32'd0);
      check_eq("cf_wait1", 32'(wait1), 32'd0);
      check_eq("cf_err3", 32'(err3), 32'(k >= 1));
      check_eq("cf_err1", 32'(err1), 32'(k >= 1));
      next_cycle();
    end
    mem_read = 1'b0; mem_write = 1'b0;
    sample();
    check_eq("cf_rel_wait3", 32'(wait3), 32'd1);
    check_eq("cf_rel_err3", 32'(err3), 32'd1);
    check_eq("cf_rel_err1", 32'(err1), 32'd1);
    next_cycle();
    sample();
    check_eq("cf_end_err3", 32'(err3), 32'd0);
    check_eq("cf_end_err1", 32'(err1), 32'd0);
    next_cycle();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; mem_read = 1'b0; mem_write = 1'b0; addr = '0; wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    sample();
    check_eq("rst_wait3", 32'(wait3), 32'd1);
    check_eq("rst_wait1", 32'(wait1), 32'd1);
    check_eq("rst_rdata3", 32'(rdata3), 32'd0);
    check_eq("rst_rdata1", 32'(rdata1), 32'd0);
    check_eq("rst_err3", 32'(err3), 32'd0);
    check_eq("rst_err1", 32'(err1), 32'd0);
    next_cycle();

    foreach (pool[i]) xact(1'b1, pool[i], 16'($urandom), 4, 1'b0);

    // Write then read back, both instances
    xact(1'b1, 8'h10, 16'h8001, 4, 1'b0);
    xact(1'b0, 8'h10, 16'h0000, 4, 1'b0);
    // LATENCY=1 read completes after one cycle; LATENCY=3 read is aborted
    xact(1'b1, 8'h00, 16'h1234, 4, 1'b0);
    xact(1'b0, 8'h00, 16'h0000, 1, 1'b0);
    xact(1'b0, 8'h00, 16'h0000, 3, 1'b0);
    // Write dropped during BUSY leaves the old word in place
    xact(1'b1, 8'h20, 16'hBEEF, 2, 1'b0);
    xact(1'b0, 8'h20, 16'h0000, 4, 1'b0);
    // Conflicts do not touch the array
    conflict(2);
    xact(1'b0, 8'h10, 16'h0000, 3, 1'b0);
    // Bus changes during BUSY are ignored
    xact(1'b1, 8'h05, 16'h0505, 4, 1'b0);
    xact(1'b1, 8'h06, 16'h0606, 4, 1'b0);
    xact(1'b0, 8'h05, 16'h0000, 5, 1'b1);
    xact(1'b1, 8'h06, 16'hA5A5, 4, 1'b1);
    xact(1'b0, 8'h06, 16'h0000, 3, 1'b0);

    // Reset during BUSY of a write to 0x30
    mem_write = 1'b1; mem_read = 1'b0; addr = 8'h30; wdata = 16'hDEAD;
    sample();
    check_eq("rb_wait3_c0", 32'(wait3), 32'd0);
    next_cycle();
    reset = 1'b1;
    sample();
    check_eq("rb_wait3_c1", 32'(wait3), 32'd0);
    next_cycle();
    reset = 1'b0; mem_write = 1'b0;
    sample();
    check_eq("rb_wait3", 32'(wait3), 32'd1);
    check_eq("rb_wait1", 32'(wait1), 32'd1);
    check_eq("rb_rdata3", 32'(rdata3), 32'd0);
    check_eq("rb_rdata1", 32'(rdata1), 32'd0);
    next_cycle();
    m1[8'h30] = 16'hDEAD;
    last3 = '0;
    last1 = '0;
    xact(1'b0, 8'h30, 16'h0000, 4, 1'b0);

    for (int it = 0; it < 80; it++) begin
      if ($urandom_range(9) == 0) begin
        conflict(int'($urandom_range(1, 3)));
      end else begin
        xact(1'($urandom_range(1)), pool[$urandom_range(7)], 16'($urandom),
             int'($urandom_range(1, 5)), 1'($urandom_range(1)));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_bus_responder.md
# mem_bus_responder

Memory-side responder for the SAM CPU bus. It accepts the read and write strobes, address and write data driven by the microprogrammed controller, and performs the access on an internal word array after a parameterised latency. It drives `wait_`, the condition input the controller's microsequencer tests to hold a microstate until the access completes. It sits between the controller/datapath bus and the main memory array.

## Interface
- `DATA_W`, 16: word width (bit 15 is the sign/opcode bit the controller inspects).
- `ADDR_W`, 8: address width; array depth is 2**ADDR_W words.
- `LATENCY`, 3: number of cycles `wait_` reads 0 for an accepted request; legal range is 1..15.
- `clk`  in  1  single clock; every state change happens on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `mem_read`  in  1  read request level.
- `mem_write`  in  1  write request level.
- `addr`  in  ADDR_W  word address (from MAR).
- `wdata`  in  DATA_W  write data (from MBR).
- `rdata`  out  DATA_W  read data; holds the last completed read.
- `wait_`  out  1  active-low stall: 0 means the access is pending and the controller must hold; 1 means ready/idle.
- `err`  out  1  registered; set for one cycle when a conflicting request (read and write both high) is seen in IDLE.

## Operation
- The FSM has three states: IDLE, BUSY, DONE.
- Define `req = mem_read ^ mem_write` and `conflict = mem_read & mem_write`.
- IDLE + `req`:
  - Latch `op` (read/write), `addr` and `wdata`.
  - If LATENCY==1, perform the access and go to DONE.
  - Otherwise load `cnt = LATENCY-2` and go to BUSY.
- IDLE + `conflict`: stay in IDLE, set `err`, and do not access the array.
- IDLE + no request: stay in IDLE.
- BUSY:
  - If `req` has dropped, abort: go to IDLE with no array write and `rdata` unchanged.
  - Else if `cnt==0`, perform the access and go to DONE.
  - Else decrement `cnt`.
  - Changes to `addr`, `wdata` or request type during BUSY are ignored; the latched values are used.
- Performing the access:
  - Write: `mem[addr_q] <= wdata_q`.
  - Read: `rdata <= mem[addr_q]`.
  - Both happen on the edge entering DONE.
- DONE: stay while `mem_read | mem_write` is high (four-phase handshake). Go to IDLE on the first cycle both are low.
- `wait_` is combinational (Mealy): `wait_ = ~((mem_read | mem_write) & (state != DONE))`. It reads 0 in the same cycle a request first appears, so the controller can never slip past on a stale ready.
- A back-to-back request needs at least one idle cycle with both strobes low between accesses.

## Timing
- Reset values: state IDLE, `cnt` 0, `rdata` 0, `err` 0. `wait_` is 1 when no strobe is high. Array contents are not reset.
- A request first high in cycle 0 gives `wait_` = 0 in cycles 0..LATENCY-1 and `wait_` = 1 from cycle LATENCY.
- `rdata` is valid from cycle LATENCY. A write is visible to a read issued in any later request.
- A request dropped before completion is aborted and has no side effects. `wait_` is 1 in the cycle after the drop.
- Reset asserted mid-BUSY forces IDLE on that edge and discards the pending write. Reset wins over every other event.
- `err` is registered: it is 1 in the cycle after the conflict is sampled, for one cycle per sampled conflict cycle.

## Structure
- Shared package `sam_pkg`:
  - state encoding (IDLE/BUSY/DONE)
  - `SAM_WORD_W = 16`
  - op encoding (`OP_READ`, `OP_WRITE`)
- One sub-module, `sam_ram_array`: synchronous single-port array with write enable and a registered read. It has no reset. The FSM, counter and `wait_` logic stay in the top module.

## Test plan
- Reset, then write 0x8001 to 0x10 with LATENCY=3 → `wait_` 0 in cycles 0–2, 1 in cycle 3. Then read 0x10 → `rdata`=0x8001 in cycle 3 of the read.
- LATENCY=1, read 0x00 after preloading 0x1234 → `wait_` 0 for exactly one cycle and `rdata`=0x1234 next cycle.
- Drop `mem_write` (addr 0x20, data 0xBEEF) in cycle 1 of BUSY → IDLE, `wait_`=1. A subsequent read of 0x20 returns the old value.
- Assert `mem_read` and `mem_write` together for 2 cycles in IDLE → `err` pulses twice, `wait_`=0, no array change. Release → `wait_`=1.
- Change `addr` from 0x05 to 0x06 during BUSY of a read → `rdata` = `mem[0x05]`.
- Assert `reset` during BUSY of a write to 0x30 → state IDLE, `rdata`=0, `mem[0x30]` unchanged.
